// File: rtl/usr_serial_ctrl_if.sv
// Parallel-word handshake between a producer and usr_serial_ctrl.
//   tx_valid : producer has a word on tx_data
//   tx_data  : word to transmit, MSB first
//   tx_ready : controller accepts a word this cycle
// master = producer side, slave = controller side.
interface usr_serial_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             tx_valid;
  logic [WIDTH-1:0] tx_data;
  logic             tx_ready;

  modport master (output tx_valid, output tx_data, input tx_ready);
  modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/usr_serial_ctrl.sv
// usr_serial_ctrl: frame sequencer that drives a universal shift register
// as a serial transmitter. A word accepted on the handshake is parallel-loaded
// into the register, then shifted out MSB first between a start bit (0) and a
// stop bit (1), each bit lasting CLKS_PER_BIT cycles, followed by GAP idle
// cycles.
// Ports:
//   clk, rst_n  : clock, synchronous active-low reset
//   tx          : handshake (tx_valid, tx_data, tx_ready), slave side
//   usr_mode    : register mode (00 hold, 01 shift left, 10 load, 11 unused)
//   usr_p_in    : parallel load value, held between frames
//   usr_s_in    : serial fill bit, constant 1
//   usr_s_out   : register MSB, drives the line during data bits
//   ser_out     : framed serial line, idles high
//   busy        : high outside IDLE
//   done        : pulse on the last cycle of the stop bit
module usr_serial_ctrl #(
  parameter int WIDTH        = 4,
  parameter int CLKS_PER_BIT = 4,
  parameter int GAP          = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  usr_serial_ctrl_if.slave tx,
  output logic [1:0]       usr_mode,
  output logic [WIDTH-1:0] usr_p_in,
  output logic             usr_s_in,
  input  logic             usr_s_out,
  output logic             ser_out,
  output logic             busy,
  output logic             done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_SHL   = 2'b01;
  localparam logic [1:0] MODE_LOAD  = 2'b10;

  typedef enum logic [2:0] {
    IDLE, LOAD, START, DATA, STOP, GAPW
  } state_t;

  state_t           state_reg, state_next;
  logic [CW-1:0]    clk_cnt_reg, clk_cnt_next;
  logic [BW-1:0]    bit_cnt_reg, bit_cnt_next;
  logic [GW-1:0]    gap_cnt_reg, gap_cnt_next;
  logic [WIDTH-1:0] p_in_reg, p_in_next;
  logic             tx_ready_c;

  logic clk_last;
  assign clk_last = (clk_cnt_reg == CLK_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      clk_cnt_reg <= '0;
      bit_cnt_reg <= '0;
      gap_cnt_reg <= '0;
      p_in_reg    <= '0;
    end else begin
      state_reg   <= state_next;
      clk_cnt_reg <= clk_cnt_next;
      bit_cnt_reg <= bit_cnt_next;
      gap_cnt_reg <= gap_cnt_next;
      p_in_reg    <= p_in_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    clk_cnt_next = clk_cnt_reg;
    bit_cnt_next = bit_cnt_reg;
    gap_cnt_next = gap_cnt_reg;
    p_in_next    = p_in_reg;
    usr_mode     = MODE_HOLD;
    ser_out      = 1'b1;
    tx_ready_c   = 1'b0;
    done         = 1'b0;

    unique case (state_reg)
      IDLE: begin
        tx_ready_c = 1'b1;
        if (tx.tx_valid) begin
          p_in_next  = tx.tx_data;
          state_next = LOAD;
        end
      end
      LOAD: begin
        usr_mode     = MODE_LOAD;
        clk_cnt_next = '0;
        state_next   = START;
      end
      START: begin
        ser_out = 1'b0;
        if (clk_last) begin
          clk_cnt_next = '0;
          bit_cnt_next = '0;
          state_next   = DATA;
        end else begin
          clk_cnt_next = clk_cnt_reg + 1'b1;
        end
      end
      DATA: begin
        // The register's MSB is already registered, so the line follows it
        // directly; the shift at the end of a bit period exposes the next bit.
        ser_out = usr_s_out;
        if (clk_last) begin
          usr_mode     = MODE_SHL;
          clk_cnt_next = '0;
          if (bit_cnt_reg == BIT_LAST) begin
            bit_cnt_next = '0;
            state_next   = STOP;
          end else begin
            bit_cnt_next = bit_cnt_reg + 1'b1;
          end
        end else begin
          clk_cnt_next = clk_cnt_reg + 1'b1;
        end
      end
      STOP: begin
        if (clk_last) begin
          done         = 1'b1;
          clk_cnt_next = '0;
          gap_cnt_next = '0;
          state_next   = (GAP > 0) ? GAPW : IDLE;
        end else begin
          clk_cnt_next = clk_cnt_reg + 1'b1;
        end
      end
      GAPW: begin
        if (gap_cnt_reg == GAP_LAST) begin
          gap_cnt_next = '0;
          state_next   = IDLE;
        end else begin
          gap_cnt_next = gap_cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign tx.tx_ready = tx_ready_c;
  assign usr_p_in    = p_in_reg;
  assign usr_s_in    = 1'b1;
  assign busy        = (state_reg != IDLE);

endmodule

// File: tb/tb_usr_serial_ctrl.sv
module tb_usr_serial_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a_n, rst_b_n;

  // Instance A: CLKS_PER_BIT=2, GAP=2.  Instance B: CLKS_PER_BIT=1, GAP=0.
  usr_serial_ctrl_if #(.WIDTH(4)) if_a ();
  usr_serial_ctrl_if #(.WIDTH(4)) if_b ();

  logic [1:0] mode_a, mode_b;
  logic [3:0] pin_a, pin_b;
  logic       sin_a, sin_b, sout_a, sout_b;
  logic       ser_a, ser_b, busy_a, busy_b, done_a, done_b;
  logic [3:0] usr_a, usr_b;

  usr_serial_ctrl #(.WIDTH(4), .CLKS_PER_BIT(2), .GAP(2)) dut_a (
    .clk(clk), .rst_n(rst_a_n), .tx(if_a.slave),
    .usr_mode(mode_a), .usr_p_in(pin_a), .usr_s_in(sin_a), .usr_s_out(sout_a),
    .ser_out(ser_a), .busy(busy_a), .done(done_a)
  );

  usr_serial_ctrl #(.WIDTH(4), .CLKS_PER_BIT(1), .GAP(0)) dut_b (
    .clk(clk), .rst_n(rst_b_n), .tx(if_b.slave),
    .usr_mode(mode_b), .usr_p_in(pin_b), .usr_s_in(sin_b), .usr_s_out(sout_b),
    .ser_out(ser_b), .busy(busy_b), .done(done_b)
  );

  // Behavioural 4-bit universal shift registers controlled by each DUT.
  always @(posedge clk) begin
    case (mode_a)
      2'b10:   usr_a <= pin_a;
      2'b01:   usr_a <= {usr_a[2:0], sin_a};
      2'b11:   usr_a <= {sin_a, usr_a[3:1]};
      default: usr_a <= usr_a;
    endcase
    case (mode_b)
      2'b10:   usr_b <= pin_b;
      2'b01:   usr_b <= {usr_b[2:0], sin_b};
      2'b11:   usr_b <= {sin_b, usr_b[3:1]};
      default: usr_b <= usr_b;
    endcase
  end
  assign sout_a = usr_a[3];
  assign sout_b = usr_b[3];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [39:0] act, input logic [39:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit sel, input logic v, input logic [3:0] d);
    if (sel) begin if_b.tx_valid = v; if_b.tx_data = d; end
    else     begin if_a.tx_valid = v; if_a.tx_data = d; end
  endtask

  // Handshakes `data`, then records the frame cycle by cycle from the LOAD
  // cycle (index 0) until tx_ready returns. len = index of the first ready
  // cycle, so handshake spacing is len+1 when tx_valid stays high.
  task automatic run_frame(input bit sel, input logic [3:0] data, input bit hold,
                           input logic [3:0] nxt, input bit noise,
                           output logic [39:0] ser_v, output int len,
                           output int n10, output int n01, output int first01,
                           output int last01, output int done_at, output int ndone);
    logic [1:0] m;
    logic       s, d, r;
    check(sel ? "hs_ready_b" : "hs_ready_a", sel ? if_b.tx_ready : if_a.tx_ready, 1);
    drive(sel, 1'b1, data);
    tick();
    drive(sel, hold, nxt);
    ser_v = '0; len = 0; n10 = 0; n01 = 0; first01 = -1; last01 = -1;
    done_at = -1; ndone = 0;
    r = sel ? if_b.tx_ready : if_a.tx_ready;
    while (r == 1'b0 && len < 40) begin
      m = sel ? mode_b : mode_a;
      s = sel ? ser_b : ser_a;
      d = sel ? done_b : done_a;
      ser_v = {ser_v[38:0], s};
      if (m == 2'b10) n10++;
      if (m == 2'b01) begin
        n01++;
        if (first01 < 0) first01 = len;
        last01 = len;
      end
      if (d) begin ndone++; done_at = len; end
      if (noise) begin
        if (len >= 1 && len <= 10) drive(sel, (len % 2 == 1), ~data ^ 4'(len));
        else drive(sel, 1'b0, nxt);
      end
      tick();
      len++;
      r = sel ? if_b.tx_ready : if_a.tx_ready;
    end
    if (len >= 40) check("frame_timeout", 40'(len), 40'd0);
  endtask

  logic [39:0] ser_v;
  int len, n10, n01, f01, l01, dat, nd;

  initial begin
    rst_a_n = 1'b0; rst_b_n = 1'b0;
    drive(0, 1'b0, 4'h0); drive(1, 1'b0, 4'h0);
    tick(); tick();
    rst_a_n = 1'b1; rst_b_n = 1'b1;

    // Reset state
    check("rst_ser_a",   ser_a, 1);
    check("rst_ready_a", if_a.tx_ready, 1);
    check("rst_busy_a",  busy_a, 0);
    check("rst_mode_a",  mode_a, 0);
    check("rst_pin_a",   pin_a, 0);
    check("rst_done_a",  done_a, 0);
    check("rst_busy_b",  busy_b, 0);
    check("rst_ser_b",   ser_b, 1);

    // Single frame 1101: LOAD, start 00, data 11110011, stop 11, gap 11
    run_frame(0, 4'b1101, 0, 4'b0000, 0, ser_v, len, n10, n01, f01, l01, dat, nd);
    $display("frame a 1101: ser=%015b len=%0d", ser_v[14:0], len);
    check("f1_ser",    ser_v[14:0], 15'b100111100111111);
    check("f1_load",   n10, 1);
    check("f1_shift",  n01, 4);
    check("f1_ndone",  nd, 1);
    check("f1_doneat", dat, 12);
    check("f1_len",    len, 15);
    check("f1_busy",   busy_a, 0);
    check("f1_pin",    pin_a, 4'b1101);

    // Back-to-back: 1010 then 0110 presented while the first frame runs
    run_frame(0, 4'b1010, 1, 4'b0110, 0, ser_v, len, n10, n01, f01, l01, dat, nd);
    $display("frame a 1010: ser=%015b len=%0d", ser_v[14:0], len);
    check("b2b_ser1",    ser_v[14:0], 15'b100110011001111);
    check("b2b_spacing", len + 1, 16);
    check("b2b_pin_hold", pin_a, 4'b1010);
    run_frame(0, 4'b0110, 0, 4'b0000, 0, ser_v, len, n10, n01, f01, l01, dat, nd);
    $display("frame a 0110: ser=%015b len=%0d", ser_v[14:0], len);
    check("b2b_ser2",   ser_v[14:0], 15'b100001111001111);
    check("b2b_pin2",   pin_a, 4'b0110);

    // CLKS_PER_BIT=1, GAP=0, 1000: LOAD 1, then 0,1,0,0,0,1
    run_frame(1, 4'b1000, 0, 4'b0000, 0, ser_v, len, n10, n01, f01, l01, dat, nd);
    $display("frame b 1000: ser=%07b len=%0d", ser_v[6:0], len);
    check("b_ser",     ser_v[6:0], 7'b1010001);
    check("b_load",    n10, 1);
    check("b_shift",   n01, 4);
    check("b_consec",  l01 - f01, 3);
    check("b_doneat",  dat, 6);
    check("b_len",     len, 7);
    check("b_busy",    busy_b, 0);

    // Reset during the second data bit of 1111 (cycles 5..6 after LOAD)
    check("mr_ready", if_a.tx_ready, 1);
    drive(0, 1'b1, 4'b1111);
    tick();
    drive(0, 1'b0, 4'b0000);
    for (int i = 0; i < 5; i++) tick();
    check("mr_busy_before", busy_a, 1);
    rst_a_n = 1'b0;
    tick();
    rst_a_n = 1'b1;
    $display("mid-frame reset: busy=%0b ser=%0b ready=%0b pin=%04b",
             busy_a, ser_a, if_a.tx_ready, pin_a);
    check("mr_busy",  busy_a, 0);
    check("mr_ser",   ser_a, 1);
    check("mr_ready2", if_a.tx_ready, 1);
    check("mr_pin",   pin_a, 0);
    check("mr_mode",  mode_a, 0);
    run_frame(0, 4'b0101, 0, 4'b0000, 0, ser_v, len, n10, n01, f01, l01, dat, nd);
    $display("frame a 0101: ser=%015b len=%0d", ser_v[14:0], len);
    check("mr_ser_new", ser_v[14:0], 15'b100001100111111);
    check("mr_len_new", len, 15);

    // Input noise during START and DATA is ignored
    run_frame(0, 4'b0011, 0, 4'b0000, 1, ser_v, len, n10, n01, f01, l01, dat, nd);
    $display("frame a 0011 noisy: ser=%015b len=%0d", ser_v[14:0], len);
    check("nz_ser",  ser_v[14:0], 15'b100000011111111);
    check("nz_len",  len, 15);
    check("nz_pin",  pin_a, 4'b0011);
    check("nz_shift", n01, 4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
